// File: rtl/imem_fetch_responder_if.sv
// Fetch-side bus between the IF stage (master) and the instruction-memory responder (slave).
interface imem_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, flush,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, flush,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one fetch in flight, fixed LATENCY, flushable, with a load port.
// Optional IMEM_ALIGN_CHECK_EN flags misaligned fetches via resp_err and zeroes the returned word.
module imem_fetch_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  imem_fetch_if.slave fetch,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 2) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic [31:0]       buf_addr_q, buf_addr_d;
  logic              buf_err_q, buf_err_d;
  logic [31:0]       resp_instr_q, resp_instr_d;
  logic [31:0]       resp_addr_q, resp_addr_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       mem_q [DEPTH];

  logic [AW-1:0]     rd_idx_s;
  logic [AW-1:0]     ld_idx_s;
  logic [31:0]       rd_instr_s;
  logic              rd_err_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              unused_ld_s;

  assign rd_idx_s    = fetch.req_addr[AW+1:2];
  assign ld_idx_s    = ld_addr[AW+1:2];
  assign unused_ld_s = ^{ld_addr[31:AW+2], ld_addr[1:0]};

  // Word captured at accept time; the misalignment check optionally overrides it.
  always_comb begin
    rd_err_s   = 1'b0;
    rd_instr_s = mem_q[rd_idx_s];
`ifdef IMEM_ALIGN_CHECK_EN
    if (fetch.req_addr[1:0] != 2'b00) begin
      rd_err_s   = 1'b1;
      rd_instr_s = 32'h0000_0000;
    end else begin
      rd_err_s   = 1'b0;
      rd_instr_s = mem_q[rd_idx_s];
    end
`endif
  end

  assign req_ready_s = rst & ((state_q == IDLE) | (state_q == RESP) | fetch.flush);
  assign accept_s    = fetch.req_valid & req_ready_s;

  // Next-state and datapath: an accept always wins, which covers both back-to-back and flush+request.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_instr_d  = buf_instr_q;
    buf_addr_d   = buf_addr_q;
    buf_err_d    = buf_err_q;
    resp_instr_d = resp_instr_q;
    resp_addr_d  = resp_addr_q;
    resp_err_d   = resp_err_q;
    if (accept_s) begin
      if (LATENCY == 1) begin
        state_d      = RESP;
        resp_instr_d = rd_instr_s;
        resp_addr_d  = fetch.req_addr;
        resp_err_d   = rd_err_s;
      end else begin
        state_d     = BUSY;
        cnt_d       = CNT_INIT;
        buf_instr_d = rd_instr_s;
        buf_addr_d  = fetch.req_addr;
        buf_err_d   = rd_err_s;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        BUSY: begin
          if (fetch.flush) begin
            state_d = IDLE;
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            state_d      = RESP;
            resp_instr_d = buf_instr_q;
            resp_addr_d  = buf_addr_q;
            resp_err_d   = buf_err_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and response registers; reset drops any fetch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      buf_instr_q  <= 32'h0000_0000;
      buf_addr_q   <= 32'h0000_0000;
      buf_err_q    <= 1'b0;
      resp_instr_q <= 32'h0000_0000;
      resp_addr_q  <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_instr_q  <= buf_instr_d;
      buf_addr_q   <= buf_addr_d;
      buf_err_q    <= buf_err_d;
      resp_instr_q <= resp_instr_d;
      resp_addr_q  <= resp_addr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Program image survives reset; a same-edge accept sees the old word (read-first).
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_idx_s] <= ld_data;
    end
  end

  assign fetch.req_ready  = req_ready_s;
  assign fetch.resp_valid = (state_q == RESP) & ~fetch.flush;
  assign fetch.resp_instr = resp_instr_q;
  assign fetch.resp_addr  = resp_addr_q;
  assign fetch.resp_err   = resp_err_q;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed scenarios then random traffic vs a transaction model.
module tb_imem_fetch_responder;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
`ifdef IMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  imem_fetch_if fif ();

  imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk    (clk),
    .rst    (rst),
    .fetch  (fif),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  // Reference model: program image plus at most one pending fetch counting edges to its response.
  logic [31:0] mdl_mem [DEPTH];
  bit          pend;
  int          rem;
  logic [31:0] p_instr, p_addr;
  logic        p_err;
  logic [31:0] last_instr, last_addr;
  logic        last_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  // One clock cycle: drive at the falling edge, check, advance the model at the rising edge.
  task automatic step(input bit rv, input logic [31:0] ra, input bit fl,
                      input bit le, input logic [31:0] la, input logic [31:0] ldv);
    bit exp_ready, exp_valid, acc;
    fif.req_valid = rv;
    fif.req_addr  = ra;
    fif.flush     = fl;
    ld_en         = le;
    ld_addr       = la;
    ld_data       = ldv;
    #1;
    exp_ready = !pend || (rem == 0) || fl;
    exp_valid = pend && (rem == 0) && !fl;
    chk_bit("req_ready", fif.req_ready, exp_ready);
    chk_bit("resp_valid", fif.resp_valid, exp_valid);
    chk("resp_instr", fif.resp_instr, last_instr);
    chk("resp_addr", fif.resp_addr, last_addr);
    chk_bit("resp_err", fif.resp_err, last_err);
    acc = rv && exp_ready;
    @(posedge clk);
    if (pend) begin
      if (rem == 0 || fl) pend = 1'b0;
      else rem = rem - 1;
    end
    if (acc) begin
      pend    = 1'b1;
      rem     = LATENCY - 1;
      p_addr  = ra;
      p_err   = ALIGN && (ra[1:0] != 2'b00);
      p_instr = p_err ? 32'h0000_0000 : mdl_mem[widx(ra)];
    end
    if (pend && rem == 0) begin
      last_instr = p_instr;
      last_addr  = p_addr;
      last_err   = p_err;
    end
    if (le) mdl_mem[widx(la)] = ldv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic fetch_req(input logic [31:0] a, input bit fl);
    step(1'b1, a, fl, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] word_a, word_b;
    fif.req_valid = 1'b0;
    fif.req_addr  = 32'd0;
    fif.flush     = 1'b0;
    ld_en         = 1'b0;
    ld_addr       = 32'd0;
    ld_data       = 32'd0;
    pend          = 1'b0;
    rem           = 0;
    last_instr    = 32'd0;
    last_addr     = 32'd0;
    last_err      = 1'b0;

    // Reset state
    #2;
    chk_bit("rst_ready", fif.req_ready, 1'b0);
    chk_bit("rst_valid", fif.resp_valid, 1'b0);
    chk("rst_instr", fif.resp_instr, 32'd0);
    chk("rst_addr", fif.resp_addr, 32'd0);
    chk_bit("rst_err", fif.resp_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_bit("rst_rel_ready", fif.req_ready, 1'b1);

    // Fill the image; word 1 gets the known instruction
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 32'd0, 1'b0, 1'b1, 32'(i * 4), (i == 1) ? 32'h0083_2000 : $urandom);

    // Basic latency and single-cycle pulse
    fetch_req(32'd4, 1'b0);
    idle(1);
    #1;
    chk_bit("lat_valid", fif.resp_valid, 1'b1);
    chk("lat_instr", fif.resp_instr, 32'h0083_2000);
    chk("lat_addr", fif.resp_addr, 32'd4);
    idle(2);

    // Back-to-back accept on the response cycle, then a wrapped address
    fetch_req(32'd0, 1'b0);
    idle(1);
    fetch_req(32'd4, 1'b0);
    idle(1);
    fetch_req(32'(4 * DEPTH + 8), 1'b0);
    idle(1);
    #1;
    chk("wrap_instr", fif.resp_instr, mdl_mem[2]);
    idle(2);

    // Flush in BUSY with no request: no response
    fetch_req(32'd16, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(3);

    // Flush together with a new request: only the new word returns
    fetch_req(32'd20, 1'b0);
    fetch_req(32'd12, 1'b1);
    idle(1);
    #1;
    chk("flushreq_addr", fif.resp_addr, 32'd12);
    idle(2);

    // Load and accept on the same edge to the same word
    word_a = 32'hA5A5_0001;
    word_b = 32'h5A5A_0002;
    step(1'b0, 32'd0, 1'b0, 1'b1, 32'd8, word_a);
    step(1'b1, 32'd8, 1'b0, 1'b1, 32'd8, word_b);
    idle(1);
    #1;
    chk("rdfirst_old", fif.resp_instr, word_a);
    idle(1);
    fetch_req(32'd8, 1'b0);
    idle(1);
    #1;
    chk("rdfirst_new", fif.resp_instr, word_b);
    idle(1);

    // Misaligned then aligned fetch
    fetch_req(32'd6, 1'b0);
    idle(1);
    #1;
    chk_bit("mis_err", fif.resp_err, ALIGN);
    idle(1);
    fetch_req(32'd8, 1'b0);
    idle(1);
    #1;
    chk_bit("al_err", fif.resp_err, 1'b0);
    idle(1);

    // Reset in the middle of a fetch
    fetch_req(32'd4, 1'b0);
    fif.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_bit("mid_rst_ready", fif.req_ready, 1'b0);
    chk_bit("mid_rst_valid", fif.resp_valid, 1'b0);
    chk("mid_rst_instr", fif.resp_instr, 32'd0);
    chk("mid_rst_addr", fif.resp_addr, 32'd0);
    chk_bit("mid_rst_err", fif.resp_err, 1'b0);
    pend       = 1'b0;
    last_instr = 32'd0;
    last_addr  = 32'd0;
    last_err   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_bit("mid_rst_rel_ready", fif.req_ready, 1'b1);
    idle(3);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
      step(bit'($urandom_range(0, 1)), ra, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), $urandom, $urandom);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
